// File: rtl/izh_pkg.sv
// rtl/izh_pkg.sv - Fixed-point helpers, FSM state type and default coefficients for the Izhikevich array
package izh_pkg;

    localparam int QW = 128;

    localparam logic signed [31:0] A_DEF      = 32'sh0000_051F;
    localparam logic signed [31:0] B_DEF      = 32'sh0000_3333;
    localparam logic signed [31:0] C_DEF      = 32'shFFBF_0000;
    localparam logic signed [31:0] D_DEF      = 32'sh0008_0000;
    localparam logic signed [31:0] V_PEAK_DEF = 32'sh001E_0000;
    localparam logic signed [31:0] K004_Q16   = 32'sh0000_0A3D;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN,
        ST_DONE
    } izh_state_e;

    // Clamp x to the signed range of a w-bit word.
    function automatic logic signed [QW-1:0] sat(input logic signed [QW-1:0] x, input int w);
        logic signed [QW-1:0] hi;
        logic signed [QW-1:0] lo;
        logic signed [QW-1:0] r;
        hi = (QW'(1) <<< (w - 1)) - QW'(1);
        lo = ~hi;
        r  = x;
        if (x > hi) begin
            r = hi;
        end else if (x < lo) begin
            r = lo;
        end
        return r;
    endfunction

    function automatic logic signed [QW-1:0] q_int(input int val, input int frac);
        return QW'(val) <<< frac;
    endfunction

    function automatic logic signed [QW-1:0] q004(input int frac);
        return (QW'(K004_Q16) <<< frac) >>> 16;
    endfunction

endpackage

// File: rtl/izh_update_pipe.sv
// rtl/izh_update_pipe.sv - Two-stage Izhikevich Euler datapath: registered products, then combinational write-back values
module izh_update_pipe
    import izh_pkg::*;
#(
    parameter int                      WIDTH    = 32,
    parameter int                      FRAC     = 16,
    parameter int                      IDX_W    = 2,
    parameter int                      DT_SHIFT = 1,
    parameter logic signed [WIDTH-1:0] A        = WIDTH'(A_DEF),
    parameter logic signed [WIDTH-1:0] B        = WIDTH'(B_DEF),
    parameter logic signed [WIDTH-1:0] C        = WIDTH'(C_DEF),
    parameter logic signed [WIDTH-1:0] D        = WIDTH'(D_DEF),
    parameter logic signed [WIDTH-1:0] V_PEAK   = WIDTH'(V_PEAK_DEF)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [IDX_W-1:0]        in_idx,
    input  logic signed [WIDTH-1:0] in_v,
    input  logic signed [WIDTH-1:0] in_u,
    input  logic signed [WIDTH-1:0] in_i,
    output logic                    out_valid,
    output logic [IDX_W-1:0]        out_idx,
    output logic signed [WIDTH-1:0] out_v_wb,
    output logic signed [WIDTH-1:0] out_u_wb,
    output logic signed [WIDTH-1:0] out_v_peak,
    output logic                    out_spike
);

    localparam int PW = 2 * WIDTH;
    localparam int SW = WIDTH + 4;
    localparam logic signed [WIDTH-1:0] K004 = WIDTH'(q004(FRAC));
    localparam logic signed [WIDTH-1:0] K5   = WIDTH'(q_int(5, FRAC));
    localparam logic signed [WIDTH-1:0] K140 = WIDTH'(q_int(140, FRAC));

    logic                    s1_valid_q, s1_valid_d;
    logic [IDX_W-1:0]        s1_idx_q, s1_idx_d;
    logic signed [WIDTH-1:0] s1_v_q, s1_v_d, s1_u_q, s1_u_d, s1_i_q, s1_i_d;
    logic signed [WIDTH-1:0] s1_p1_q, s1_p1_d, s1_p2_q, s1_p2_d, s1_bv_q, s1_bv_d;

    logic signed [PW-1:0]    sq_prod, p1_prod, p2_prod, bv_prod, du_prod;
    logic signed [WIDTH-1:0] sq, diff, du, v_next, u_next, u_spk;
    logic signed [SW-1:0]    dv, v_sum, u_sum;
    logic                    spike;

    always_comb begin
        sq_prod    = PW'(in_v) * PW'(in_v);
        sq         = WIDTH'(sat(QW'(sq_prod >>> FRAC), WIDTH));
        p1_prod    = PW'(K004) * PW'(sq);
        p2_prod    = PW'(K5) * PW'(in_v);
        bv_prod    = PW'(B) * PW'(in_v);
        s1_valid_d = in_valid;
        s1_idx_d   = in_idx;
        s1_v_d     = in_v;
        s1_u_d     = in_u;
        s1_i_d     = in_i;
        s1_p1_d    = WIDTH'(sat(QW'(p1_prod >>> FRAC), WIDTH));
        s1_p2_d    = WIDTH'(sat(QW'(p2_prod >>> FRAC), WIDTH));
        s1_bv_d    = WIDTH'(sat(QW'(bv_prod >>> FRAC), WIDTH));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            s1_v_q     <= '0;
            s1_u_q     <= '0;
            s1_i_q     <= '0;
            s1_p1_q    <= '0;
            s1_p2_q    <= '0;
            s1_bv_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_idx_q   <= s1_idx_d;
            s1_v_q     <= s1_v_d;
            s1_u_q     <= s1_u_d;
            s1_i_q     <= s1_i_d;
            s1_p1_q    <= s1_p1_d;
            s1_p2_q    <= s1_p2_d;
            s1_bv_q    <= s1_bv_d;
        end
    end

    // Sums carry 4 guard bits so that only the final saturation can clip.
    always_comb begin
        dv      = SW'(s1_p1_q) + SW'(s1_p2_q) + SW'(K140) - SW'(s1_u_q) + SW'(s1_i_q);
        v_sum   = SW'(s1_v_q) + (dv >>> DT_SHIFT);
        v_next  = WIDTH'(sat(QW'(v_sum), WIDTH));
        diff    = WIDTH'(sat(QW'(SW'(s1_bv_q) - SW'(s1_u_q)), WIDTH));
        du_prod = PW'(A) * PW'(diff);
        du      = WIDTH'(sat(QW'(du_prod >>> FRAC), WIDTH));
        u_sum   = SW'(s1_u_q) + SW'(du >>> DT_SHIFT);
        u_next  = WIDTH'(sat(QW'(u_sum), WIDTH));
        u_spk   = WIDTH'(sat(QW'(SW'(u_next) + SW'(D)), WIDTH));
        spike   = (v_next >= V_PEAK);

        out_valid  = s1_valid_q;
        out_idx    = s1_idx_q;
        out_spike  = s1_valid_q && spike;
        out_v_peak = v_next;
        out_v_wb   = spike ? C : v_next;
        out_u_wb   = spike ? u_spk : u_next;
    end

endmodule

// File: rtl/izh_neuron_array.sv
// rtl/izh_neuron_array.sv - Time-multiplexed Izhikevich neuron array; IZH_SPIKE_CNT_EN adds a saturating spike counter
module izh_neuron_array
    import izh_pkg::*;
#(
    parameter int                      N        = 4,
    parameter int                      WIDTH    = 32,
    parameter int                      FRAC     = 16,
    parameter logic signed [WIDTH-1:0] A        = WIDTH'(A_DEF),
    parameter logic signed [WIDTH-1:0] B        = WIDTH'(B_DEF),
    parameter logic signed [WIDTH-1:0] C        = WIDTH'(C_DEF),
    parameter logic signed [WIDTH-1:0] D        = WIDTH'(D_DEF),
    parameter logic signed [WIDTH-1:0] V_PEAK   = WIDTH'(V_PEAK_DEF),
    parameter int                      DT_SHIFT = 1,
    localparam int                     IDX_W    = (N > 1) ? $clog2(N) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic [IDX_W-1:0]        cur_idx,
    input  logic signed [WIDTH-1:0] cur_i,
    output logic                    spike_valid,
    output logic [IDX_W-1:0]        spike_idx,
    output logic signed [WIDTH-1:0] v_mon
`ifdef IZH_SPIKE_CNT_EN
    ,
    output logic [15:0]             spike_count
`endif
);

    localparam logic [IDX_W-1:0]        LAST_IDX = IDX_W'(N - 1);
    localparam logic signed [2*WIDTH-1:0] BC_PROD = (2*WIDTH)'(B) * (2*WIDTH)'(C);
    localparam logic signed [WIDTH-1:0] U_RST    = WIDTH'(sat(QW'(BC_PROD >>> FRAC), WIDTH));

    izh_state_e              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    drain_q, drain_d;
    logic signed [WIDTH-1:0] v_q [N];
    logic signed [WIDTH-1:0] v_d [N];
    logic signed [WIDTH-1:0] u_q [N];
    logic signed [WIDTH-1:0] u_d [N];
    logic                    mon_valid_q, mon_valid_d;
    logic                    spike_valid_q, spike_valid_d;
    logic [IDX_W-1:0]        spike_idx_q, spike_idx_d;
    logic signed [WIDTH-1:0] v_mon_q, v_mon_d;

    logic                    pipe_valid, pipe_spike;
    logic [IDX_W-1:0]        pipe_idx;
    logic signed [WIDTH-1:0] pipe_v_wb, pipe_u_wb, pipe_v_peak;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        drain_d = drain_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_ISSUE;
                    idx_d   = '0;
                end
            end
            ST_ISSUE: begin
                if (idx_q == LAST_IDX) begin
                    state_d = ST_DRAIN;
                    idx_d   = '0;
                    drain_d = 1'b0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DRAIN: begin
                if (drain_q) begin
                    state_d = ST_DONE;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    izh_update_pipe #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .IDX_W   (IDX_W),
        .DT_SHIFT(DT_SHIFT),
        .A       (A),
        .B       (B),
        .C       (C),
        .D       (D),
        .V_PEAK  (V_PEAK)
    ) u_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (state_q == ST_ISSUE),
        .in_idx    (idx_q),
        .in_v      (v_q[idx_q]),
        .in_u      (u_q[idx_q]),
        .in_i      (cur_i),
        .out_valid (pipe_valid),
        .out_idx   (pipe_idx),
        .out_v_wb  (pipe_v_wb),
        .out_u_wb  (pipe_u_wb),
        .out_v_peak(pipe_v_peak),
        .out_spike (pipe_spike)
    );

    // Each neuron is issued once per step, so the write port never races the read.
    always_comb begin
        v_d = v_q;
        u_d = u_q;
        if (pipe_valid) begin
            v_d[pipe_idx] = pipe_v_wb;
            u_d[pipe_idx] = pipe_u_wb;
        end
        mon_valid_d   = pipe_valid;
        spike_valid_d = pipe_spike;
        spike_idx_d   = pipe_spike ? pipe_idx : '0;
        v_mon_d       = pipe_v_peak;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            drain_q       <= 1'b0;
            mon_valid_q   <= 1'b0;
            spike_valid_q <= 1'b0;
            spike_idx_q   <= '0;
            v_mon_q       <= '0;
            for (int k = 0; k < N; k++) begin
                v_q[k] <= C;
                u_q[k] <= U_RST;
            end
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            drain_q       <= drain_d;
            mon_valid_q   <= mon_valid_d;
            spike_valid_q <= spike_valid_d;
            spike_idx_q   <= spike_idx_d;
            v_mon_q       <= v_mon_d;
            v_q           <= v_d;
            u_q           <= u_d;
        end
    end

    assign busy        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    assign done        = (state_q == ST_DONE);
    assign cur_idx     = idx_q;
    assign spike_valid = spike_valid_q;
    assign spike_idx   = spike_idx_q;
    assign v_mon       = mon_valid_q ? v_mon_q : '0;

`ifdef IZH_SPIKE_CNT_EN
    logic [15:0] spike_count_q, spike_count_d;

    always_comb begin
        spike_count_d = spike_count_q;
        if (spike_valid_q && (spike_count_q != 16'hFFFF)) begin
            spike_count_d = spike_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spike_count_q <= '0;
        end else begin
            spike_count_q <= spike_count_d;
        end
    end

    assign spike_count = spike_count_q;
`endif

endmodule

// File: tb/tb_izh_neuron_array.sv
// tb/tb_izh_neuron_array.sv - Scoreboard bench for izh_neuron_array with hand-computed fixed-point vectors
module tb_izh_neuron_array;

    localparam int N = 4;
    localparam logic [31:0] C_V     = 32'hFFBF_0000;
    localparam logic [31:0] U_RST   = 32'hFFF3_000D;
    localparam logic [31:0] V_STEP0 = 32'hFFBD_7C58;
    localparam logic [31:0] V_I1000 = 32'h01B1_7C58;
    localparam logic [31:0] V_IMAX  = 32'h3FBC_FC58;
    localparam logic [31:0] U_SPK   = 32'hFFFB_000D;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, spike_valid;
    logic [1:0]  cur_idx, spike_idx;
    logic [31:0] cur_i, v_mon;
`ifdef IZH_SPIKE_CNT_EN
    logic [15:0] spike_count;
`endif

    logic [31:0] cur_tab [N];
    logic [31:0] exp_v [N];
    logic        exp_s [N];
    logic        exp_cv [N];
    logic [31:0] st_v [N];
    logic [31:0] st_u [N];

    typedef struct packed {
        logic [1:0]  idx;
        logic [31:0] v;
        logic        spike;
        logic        chk_v;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    assign cur_i = cur_tab[cur_idx];

    izh_neuron_array #(.N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .cur_idx    (cur_idx),
        .cur_i      (cur_i),
        .spike_valid(spike_valid),
        .spike_idx  (spike_idx),
        .v_mon      (v_mon)
`ifdef IZH_SPIKE_CNT_EN
        ,
        .spike_count(spike_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (dut.mon_valid_q) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: write-back seen with no expected entry, v_mon=%h", v_mon);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.chk_v) check("v_mon", v_mon, mon_e.v);
                    check("spike_valid", 32'(spike_valid), 32'(mon_e.spike));
                    if (mon_e.spike) check("spike_idx", 32'(spike_idx), 32'(mon_e.idx));
                end
            end else if (spike_valid) begin
                checks++;
                errors++;
                $display("FAIL spike_no_wb: spike_valid=1 without write-back, required 0");
            end
        end
    end

    task automatic check_state();
        for (int k = 0; k < N; k++) begin
            check("state_v", dut.v_q[k], st_v[k]);
            check("state_u", dut.u_q[k], st_u[k]);
        end
    endtask

    task automatic do_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic run_step(input bit hold);
        int cyc;
        for (int k = 0; k < N; k++) begin
            exp_q.push_back('{idx: 2'(k), v: exp_v[k], spike: exp_s[k], chk_v: exp_cv[k]});
        end
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
        cyc = 1;
        while (!done && cyc < 40) begin
            if (cyc <= N) begin
                check("cur_idx", 32'(cur_idx), 32'(cyc - 1));
                check("busy_step", 32'(busy), 32'd1);
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        check("done_latency", cyc, N + 3);
        @(posedge clk);
        #1;
        start = 1'b0;
        check("done_pulse", {busy, done}, 32'd0);
    endtask

    task automatic set_all(input logic [31:0] i, input logic [31:0] v, input logic s,
                           input logic [31:0] sv, input logic [31:0] su);
        for (int k = 0; k < N; k++) begin
            cur_tab[k] = i;
            exp_v[k]   = v;
            exp_s[k]   = s;
            exp_cv[k]  = 1'b1;
            st_v[k]    = sv;
            st_u[k]    = su;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int dones;
        set_all(32'h0, V_STEP0, 1'b0, C_V, U_RST);
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spike_valid", 32'(spike_valid), 32'd0);
        check("rst_spike_idx", 32'(spike_idx), 32'd0);
        check("rst_cur_idx", 32'(cur_idx), 32'd0);
        check("rst_v_mon", v_mon, 32'd0);
        check_state();
        @(negedge clk) rst_n = 1'b1;

        // Zero current: every neuron drifts to just below -66.5, u unchanged
        set_all(32'h0, V_STEP0, 1'b0, V_STEP0, U_RST);
        run_step(1'b0);
        check_state();

        // Large current on neuron 2 only
        do_reset();
        set_all(32'h0, V_STEP0, 1'b0, V_STEP0, U_RST);
        cur_tab[2] = 32'h03E8_0000;
        exp_v[2]   = V_I1000;
        exp_s[2]   = 1'b1;
        st_v[2]    = C_V;
        st_u[2]    = U_SPK;
        run_step(1'b0);
        check_state();

        // Near-full-scale current on all neurons: no wrap, all spike
        do_reset();
        set_all(32'h7FFF_0000, V_IMAX, 1'b1, C_V, U_SPK);
        run_step(1'b0);
        check_state();

        // start held high through the whole step and into DONE
        do_reset();
        set_all(32'h0, V_STEP0, 1'b0, V_STEP0, U_RST);
        run_step(1'b1);
        repeat (4) @(posedge clk);
        #1;
        check("hold_no_restart", 32'(busy), 32'd0);
        check("hold_queue_empty", exp_q.size(), 32'd0);
        check_state();

        // Reset asserted while neuron 1 is being issued
        do_reset();
        cur_tab[1] = 32'h7FFF_0000;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        check("abort_at_idx1", 32'(cur_idx), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_cur_idx", 32'(cur_idx), 32'd0);
        check("abort_v_mon", v_mon, 32'd0);
        check("abort_spike", 32'(spike_valid), 32'd0);
        check("abort_pipe", 32'(dut.u_pipe.s1_valid_q), 32'd0);
        set_all(32'h0, V_STEP0, 1'b0, C_V, U_RST);
        check_state();
        @(negedge clk) rst_n = 1'b1;
        dones = 0;
        repeat (N + 6) begin
            @(posedge clk);
            #1;
            if (done) dones++;
        end
        check("abort_no_done", dones, 0);

`ifdef IZH_SPIKE_CNT_EN
        do_reset();
        set_all(32'h7FFF_0000, V_IMAX, 1'b1, C_V, U_SPK);
        for (int k = 0; k < N; k++) exp_cv[k] = 1'b0;
        repeat (3) run_step(1'b0);
        check("spike_count_12", 32'(spike_count), 32'd12);
        @(negedge clk) force dut.spike_count_q = 16'hFFFE;
        @(posedge clk);
        #1 release dut.spike_count_q;
        run_step(1'b0);
        check("spike_count_sat", 32'(spike_count), 32'h0000_FFFF);
`endif

        check("final_queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
